lut8_cfg_loader: RTL and testbench

Configuration controller for the 8-entry serial-shift lookup table: an 8-bit shift register with shift-enable and serial input, read through a 3-bit address mux. Accepts an 8-bit truth table over a valid/ready handshake and shifts it in MSB-first, one bit per cycle. Gates lookups so that `z` is only reported valid once a complete table is resident. Sits between the configuration bus and the LUT datapath, which it instantiates.

---
 rtl/lut_cfg_pkg.sv | 15 +
 rtl/lut8_sr.sv | 34 +++
 rtl/lut8_cfg_loader.sv | 87 ++++++++
 tb/tb_lut8_cfg_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the 8-entry LUT configuration loader and its datapath.
package lut_cfg_pkg;

   // Number of table entries and the address width that selects one of them.
   localparam int LUT_DEPTH = 8;
   localparam int LUT_ABITS = 3;

   // Controller state: no table yet, table being shifted in, table resident.
   typedef enum logic [1:0] {
      UNCONFIG = 2'd0,
      SHIFT    = 2'd1,
      READY    = 2'd2
   } cfg_state_e;

endpackage : lut_cfg_pkg

// File: rtl/lut8_sr.sv
// LUT datapath: 8-bit serial-in shift register read through a 3-bit address mux.
// Bits enter at Q[0] and move up, so the first bit shifted ends up in Q[7].
module lut8_sr
   import lut_cfg_pkg::*;
(
   input  logic clk,
   input  logic areset,
   input  logic enable,
   input  logic S,
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Z
);

   logic [LUT_DEPTH-1:0] q_q;
   logic [LUT_ABITS-1:0] addr;

   // Shift one serial bit in per enabled cycle; hold otherwise.
   // NOTE: the table storage gets the async clear too, so a reset mid-load
   // never leaves a half-shifted table behind for the next lookup.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         q_q <= '0;
      end else if (enable) begin
         q_q <= {q_q[LUT_DEPTH-2:0], S};
      end
   end

   // A is the address MSB, C the LSB.
   assign addr = {A, B, C};
   assign Z    = q_q[addr];

endmodule : lut8_sr

// File: rtl/lut8_cfg_loader.sv
// Configuration controller for the 8-entry serial-shift LUT. Accepts a truth
// table over valid/ready, shifts it in MSB-first over 8 cycles, and reports
// lookups as valid only once a complete table is resident.
module lut8_cfg_loader
   import lut_cfg_pkg::*;
#(
   parameter int W_CNT = 3
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 cfg_valid,
   input  logic [LUT_DEPTH-1:0] cfg_data,
   output logic                 cfg_ready,
   output logic                 busy,
   output logic                 sr_enable,
   output logic                 sr_s,
   input  logic [LUT_ABITS-1:0] sel,
   output logic                 z,
   output logic                 z_valid
);

   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(LUT_DEPTH - 1);

   cfg_state_e           state_q;
   logic [LUT_DEPTH-1:0] hold_q;
   logic [W_CNT-1:0]     cnt_q;
   logic                 lut_z;
   logic                 xfer;

   // A word is taken whenever we are not mid-load and the sender offers one.
   assign xfer = cfg_valid && cfg_ready;

   // Load FSM: capture on transfer, then shift the hold register out MSB-first.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, which keeps hold/cnt/state in lockstep.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= UNCONFIG;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            UNCONFIG, READY: begin
               if (xfer) begin
                  hold_q  <= cfg_data;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               hold_q <= {hold_q[LUT_DEPTH-2:0], 1'b0};
               cnt_q  <= cnt_q + W_CNT'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= READY;
               end
            end
            default: begin
               state_q <= UNCONFIG;
            end
         endcase
      end
   end

   // Status decodes straight from the state register.
   assign cfg_ready = (state_q != SHIFT);
   assign busy      = (state_q == SHIFT);
   assign z_valid   = (state_q == READY);

   // Drive the shift register only while loading; the serial bit is the hold MSB.
   assign sr_enable = (state_q == SHIFT);
   assign sr_s      = sr_enable & hold_q[LUT_DEPTH-1];

   lut8_sr u_sr (
      .clk    (clk),
      .areset (areset),
      .enable (sr_enable),
      .S      (sr_s),
      .A      (sel[2]),
      .B      (sel[1]),
      .C      (sel[0]),
      .Z      (lut_z)
   );

   // Lookups are gated so a partial or reloading table never reads as valid.
   assign z = z_valid & lut_z;

endmodule : lut8_cfg_loader

// File: tb/tb_lut8_cfg_loader.sv
// Self-checking bench for lut8_cfg_loader: directed loads, back-pressure,
// reload, reset mid-load and a random soak against a behavioral table model.
module tb_lut8_cfg_loader;
   import lut_cfg_pkg::*;

   logic       clk;
   logic       areset;
   logic       cfg_valid;
   logic [7:0] cfg_data;
   logic       cfg_ready;
   logic       busy;
   logic       sr_enable;
   logic       sr_s;
   logic [2:0] sel;
   logic       z;
   logic       z_valid;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic rdy;
      logic bsy;
      logic en;
      logic s;
      logic zz;
      logic zv;
   } exp_t;

   exp_t sb[$];

   // Behavioral model: a pending table that becomes the resident table
   // exactly 8 edges after it is accepted.
   logic       m_loading;
   int         m_left;
   logic [7:0] m_pending;
   logic [7:0] m_table;
   logic       m_valid;

   lut8_cfg_loader #(.W_CNT(3)) dut (
      .clk       (clk),
      .areset    (areset),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .busy      (busy),
      .sr_enable (sr_enable),
      .sr_s      (sr_s),
      .sel       (sel),
      .z         (z),
      .z_valid   (z_valid)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 1'b0;
      m_left    = 0;
      m_pending = '0;
      m_table   = '0;
      m_valid   = 1'b0;
   endtask

   function automatic exp_t model_out(input logic [2:0] s);
      exp_t e;
      e.rdy = !m_loading;
      e.bsy = m_loading;
      e.en  = m_loading;
      e.s   = m_loading ? m_pending[m_left-1] : 1'b0;
      e.zv  = m_valid;
      e.zz  = m_valid ? m_table[s] : 1'b0;
      return e;
   endfunction

   task automatic model_edge(input logic v, input logic [7:0] d);
      if (m_loading) begin
         m_left--;
         if (m_left == 0) begin
            m_loading = 1'b0;
            m_valid   = 1'b1;
            m_table   = m_pending;
         end
      end else if (v) begin
         m_loading = 1'b1;
         m_left    = 8;
         m_pending = d;
         m_valid   = 1'b0;
      end
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "/sb_empty"}, 8'd0, 8'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "/cfg_ready"}, {7'd0, cfg_ready}, {7'd0, e.rdy});
      chk({tag, "/busy"},      {7'd0, busy},      {7'd0, e.bsy});
      chk({tag, "/sr_enable"}, {7'd0, sr_enable}, {7'd0, e.en});
      chk({tag, "/sr_s"},      {7'd0, sr_s},      {7'd0, e.s});
      chk({tag, "/z_valid"},   {7'd0, z_valid},   {7'd0, e.zv});
      chk({tag, "/z"},         {7'd0, z},         {7'd0, e.zz});
   endtask

   // One clock cycle: entered and left at 1 time unit after a rising edge.
   task automatic tick(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input bit sweep, input string tag);
      cfg_valid = v;
      cfg_data  = d;
      if (sweep) begin
         for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            sb.push_back(model_out(3'(i)));
            #1;
            pop_compare($sformatf("%s/sel%0d", tag, i));
         end
      end else begin
         sel = s;
         sb.push_back(model_out(s));
         #2;
         pop_compare(tag);
      end
      model_edge(v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 3'(i), 1'b0, tag);
   endtask

   initial begin
      areset    = 1'b1;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      sel       = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      areset = 1'b0;

      // Reset state, z swept over all addresses.
      tick(1'b0, 8'h00, 3'd0, 1'b1, "reset");
      chk("reset/state", {6'd0, dut.state_q}, {6'd0, UNCONFIG});

      // Load 0xA5: transfer, 8 shift cycles, then sweep the table.
      tick(1'b1, 8'hA5, 3'd0, 1'b0, "a5_xfer");
      idle(8, "a5_shift");
      tick(1'b0, 8'h00, 3'd0, 1'b1, "a5_table");

      // Back-pressure: 0x3C held valid throughout a 0x96 load.
      tick(1'b1, 8'h96, 3'd0, 1'b0, "bp_xfer96");
      for (int i = 0; i < 8; i++) tick(1'b1, 8'h3C, 3'(i), 1'b0, "bp_hold3c");
      tick(1'b1, 8'h3C, 3'd0, 1'b1, "bp_table96");
      cfg_valid = 1'b0;
      idle(8, "bp_shift3c");
      tick(1'b0, 8'h00, 3'd0, 1'b1, "bp_table3c");

      // Reload from READY with 0x01.
      tick(1'b1, 8'h01, 3'd5, 1'b0, "rl_xfer");
      idle(8, "rl_shift");
      tick(1'b0, 8'h00, 3'd0, 1'b1, "rl_table");

      // Reset after E4 of a 0xFF load.
      tick(1'b1, 8'hFF, 3'd0, 1'b0, "mr_xfer");
      idle(4, "mr_shift");
      areset    = 1'b1;
      cfg_valid = 1'b0;
      model_reset();
      #2;
      sb.push_back(model_out(sel));
      pop_compare("mr_in_reset");
      @(posedge clk);
      #1;
      chk("mr/q_cleared", dut.u_sr.q_q, 8'h00);
      chk("mr/state", {6'd0, dut.state_q}, {6'd0, UNCONFIG});
      areset = 1'b0;
      tick(1'b0, 8'h00, 3'd0, 1'b1, "mr_after");
      tick(1'b1, 8'h80, 3'd0, 1'b0, "mr_xfer80");
      idle(8, "mr_shift80");
      tick(1'b0, 8'h00, 3'd0, 1'b1, "mr_table80");

      // Random soak against the model.
      for (int i = 0; i < 500; i++) begin
         tick(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 8'($urandom()),
              3'($urandom_range(0, 7)), 1'b0, "soak");
      end

      if (sb.size() != 0) chk("sb/leftover", 8'(sb.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_lut8_cfg_loader
